// File: rtl/gcm_ks_xor_engine.sv
// Keystream XOR engine: requests 512-bit keystream blocks and XORs 128-bit lanes onto a beat stream.
// Optional build macro GCM_KSX_ZERO_PAD_EN zeroes output bytes whose keep bit is clear.
module gcm_ks_xor_engine #(
  parameter int unsigned KS_TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         algo_sel,
  output logic         busy,
  output logic         ks_err,
  output logic         ks_req,
  input  logic         ks_valid,
  input  logic [511:0] ks_data,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  input  logic [15:0]  in_keep,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic [15:0]  out_keep,
  output logic         out_last,
  input  logic         out_ready
);

  localparam int unsigned CntW = (KS_TIMEOUT > 1) ? $clog2(KS_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWaitKs, StXor} state_e;

  state_e         state_q;
  logic           mode_q;
  logic [1:0]     lane_q;
  logic [511:0]   ks_buf_q;
  logic [CntW-1:0] cnt_q;
  logic           busy_q, ks_err_q, ks_req_q, out_valid_q, out_last_q;
  logic [127:0]   out_data_q;
  logic [15:0]    out_keep_q;

  logic [127:0]   lane_ks, xor_data, res_data;
  logic           in_hs, last_lane, ks_expired, in_ready_c;

  always_comb begin
    lane_ks    = ks_buf_q[128*lane_q +: 128];
    xor_data   = in_data ^ lane_ks;
    in_ready_c = (state_q == StXor) && (!out_valid_q || out_ready);
    in_hs      = in_valid && in_ready_c;
    last_lane  = mode_q ? (lane_q == 2'd3) : 1'b1;
    ks_expired = (KS_TIMEOUT != 0) && (32'(cnt_q) >= KS_TIMEOUT - 1);
`ifdef GCM_KSX_ZERO_PAD_EN
    res_data = '0;
    for (int i = 0; i < 16; i++) begin
      res_data[8*i +: 8] = in_keep[i] ? xor_data[8*i +: 8] : 8'h00;
    end
`else
    res_data = xor_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      lane_q      <= 2'd0;
      ks_buf_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ks_err_q    <= 1'b0;
      ks_req_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      ks_req_q <= 1'b0;
      if (out_ready) out_valid_q <= 1'b0;
      if (in_hs) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res_data;
        out_keep_q  <= in_keep;
        out_last_q  <= in_last;
      end
      unique case (state_q)
        StIdle: begin
          if (start && !out_valid_q) begin
            mode_q   <= algo_sel;
            ks_err_q <= 1'b0;
            ks_req_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StReq;
          end
        end
        StReq: begin
          // The request cycle itself counts toward the timeout window.
          cnt_q   <= CntW'(1);
          state_q <= StWaitKs;
        end
        StWaitKs: begin
          if (ks_valid) begin
            ks_buf_q <= ks_data;
            lane_q   <= 2'd0;
            state_q  <= StXor;
          end else if (ks_expired) begin
            ks_err_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StXor: begin
          if (in_hs) begin
            if (in_last) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else if (last_lane) begin
              ks_req_q <= 1'b1;
              state_q  <= StReq;
            end else begin
              lane_q <= lane_q + 2'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign ks_err    = ks_err_q;
  assign ks_req    = ks_req_q;
  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;

endmodule
